// File: rtl/conv3x3_stream_if.sv
// Stream, coefficient and frame-control signals of the 3x3 convolution engine.
// master drives pixels, coefficients and start, and consumes results.
// slave is the engine.
interface conv3x3_stream_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 20
);
  logic                     coef_wr;
  logic [3:0]               coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     start;
  logic                     pix_valid;
  logic [DATA_W-1:0]        pix_in;
  logic                     pix_ready;
  logic                     out_valid;
  logic signed [ACC_W-1:0]  out_data;
  logic                     out_ready;
  logic                     busy;
  logic                     done;

  modport master (
    output coef_wr, coef_addr, coef_data, start, pix_valid, pix_in, out_ready,
    input  pix_ready, out_valid, out_data, busy, done
  );

  modport slave (
    input  coef_wr, coef_addr, coef_data, start, pix_valid, pix_in, out_ready,
    output pix_ready, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 valid convolution over a raster-order image.
// Two line buffers plus a 3x3 window feed a nine-tap MAC.  One output
// register with valid/ready; optional ReLU clamp on the result.
//
//   state | meaning
//   IDLE  | coefficients writable, waiting for start
//   RUN   | accepting pixels, emitting one result per full window
//   DRAIN | all pixels in, waiting for the last result to leave
module conv3x3_stream #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ACC_W  = 20,
  parameter bit RELU   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  conv3x3_stream_if.slave sif
);
  localparam int PW = DATA_W + COEF_W + 1;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state_q, state_d;
  logic   done_q, done_d;

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;

  logic signed [COEF_W-1:0] coef_q [9];
  // lb_top holds row r-2, lb_mid holds row r-1, both indexed by column
  logic [DATA_W-1:0] lb_top [IMG_W];
  logic [DATA_W-1:0] lb_mid [IMG_W];
  logic [DATA_W-1:0] win_q [3][3];
  logic [DATA_W-1:0] win_n [3][3];

  logic pix_rdy, accept, last_pix, win_full;
  logic ov_q;
  logic signed [ACC_W-1:0] od_q, acc, res;
  logic signed [PW-1:0] px, cf, prod;

  assign pix_rdy  = (state_q == RUN) && (!ov_q || sif.out_ready);
  assign accept   = sif.pix_valid && pix_rdy;
  assign last_pix = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
  assign win_full = (row_q >= RW'(2)) && (col_q >= CW'(2));

  assign sif.pix_ready = pix_rdy;
  assign sif.out_valid = ov_q;
  assign sif.out_data  = od_q;
  assign sif.busy      = (state_q != IDLE);
  assign sif.done      = done_q;

  // state and done-pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // next-state logic; done is registered so it lines up with the return to IDLE
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE:    if (sif.start) state_d = RUN;
      RUN:     if (accept && last_pix) state_d = DRAIN;
      DRAIN:   if (!ov_q || sif.out_ready) begin
                 state_d = IDLE;
                 done_d  = 1'b1;
               end
      default: state_d = IDLE;
    endcase
  end

  // raster position of the next pixel to be accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (state_q == IDLE && sif.start) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_q == CW'(IMG_W - 1)) begin
        col_q <= '0;
        row_q <= row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  // coefficient registers, writable only while idle; addresses above 8 are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) coef_q[k] <= '0;
    end else if (state_q == IDLE && sif.coef_wr && sif.coef_addr <= 4'd8) begin
      coef_q[sif.coef_addr] <= sif.coef_data;
    end
  end

  // window after this accept: shift left, new column from line buffers and input
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      win_n[i][0] = win_q[i][1];
      win_n[i][1] = win_q[i][2];
    end
    win_n[0][2] = lb_top[col_q];
    win_n[1][2] = lb_mid[col_q];
    win_n[2][2] = sif.pix_in;
  end

  // line buffers and window advance on every accept
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < IMG_W; k++) begin
        lb_top[k] <= '0;
        lb_mid[k] <= '0;
      end
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) win_q[i][j] <= '0;
    end else if (accept) begin
      lb_top[col_q] <= lb_mid[col_q];
      lb_mid[col_q] <= sif.pix_in;
      win_q <= win_n;
    end
  end

  // nine-tap MAC on the post-shift window; pixels are unsigned so zero-extend
  always_comb begin
    acc  = '0;
    px   = '0;
    cf   = '0;
    prod = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        px   = {{(COEF_W + 1){1'b0}}, win_n[i][j]};
        cf   = {{(DATA_W + 1){coef_q[3*i+j][COEF_W-1]}}, coef_q[3*i+j]};
        prod = px * cf;
        acc  = acc + {{(ACC_W - PW){prod[PW-1]}}, prod};
      end
    end
    if (RELU && acc < 0) res = '0;
    else                 res = acc;
  end

  // single result register; a reload in the same cycle as a handshake keeps valid up
  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q <= 1'b0;
      od_q <= '0;
    end else if (accept && win_full) begin
      ov_q <= 1'b1;
      od_q <= res;
    end else if (sif.out_ready) begin
      ov_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream: two instances (RELU off / on) share one
// stimulus stream; results are checked against hand-derived window formulas.
module tb_conv3x3_stream;
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 8;
  localparam int ACC_W  = 20;
  localparam int K_ID = 0, K_ONES = 1, K_NEG = 2;
  localparam int P_RAMP = 0, P_FULL = 1;
  localparam int NRES = (IMG_W - 2) * (IMG_H - 2);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv3x3_stream_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) bus_a ();
  conv3x3_stream_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) bus_b ();

  assign bus_b.coef_wr   = bus_a.coef_wr;
  assign bus_b.coef_addr = bus_a.coef_addr;
  assign bus_b.coef_data = bus_a.coef_data;
  assign bus_b.start     = bus_a.start;
  assign bus_b.pix_valid = bus_a.pix_valid;
  assign bus_b.pix_in    = bus_a.pix_in;
  assign bus_b.out_ready = bus_a.out_ready;

  conv3x3_stream #(.DATA_W(DATA_W), .COEF_W(COEF_W), .IMG_W(IMG_W), .IMG_H(IMG_H),
                   .ACC_W(ACC_W), .RELU(1'b0)) dut_a (.clk(clk), .rst(rst), .sif(bus_a));
  conv3x3_stream #(.DATA_W(DATA_W), .COEF_W(COEF_W), .IMG_W(IMG_W), .IMG_H(IMG_H),
                   .ACC_W(ACC_W), .RELU(1'b1)) dut_b (.clk(clk), .rst(rst), .sif(bus_b));

  int n_chk = 0;
  int n_err = 0;
  int exp_a[$];
  int exp_b[$];
  int n_res = 0;
  int cyc_n = 0;
  int first_acc = -1;
  int first_ov  = -1;
  int last_hs   = -1;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  function automatic int pix(input int pat, input int r, input int c);
    return (pat == P_RAMP) ? (8 * r + c) : 255;
  endfunction

  // expected result for the window whose bottom-right pixel is (r, c)
  function automatic int kexp(input int k, input int pat, input int r, input int c);
    int s = 0;
    case (k)
      K_ID:    s = pix(pat, r - 1, c - 1);
      K_NEG:   s = -pix(pat, r - 2, c - 2);
      default: for (int i = 0; i < 3; i++)
                 for (int j = 0; j < 3; j++) s += pix(pat, r - 2 + i, c - 2 + j);
    endcase
    return s;
  endfunction

  task automatic build_exp(input int k, input int pat);
    int v;
    exp_a.delete();
    exp_b.delete();
    for (int r = 2; r < IMG_H; r++)
      for (int c = 2; c < IMG_W; c++) begin
        v = kexp(k, pat, r, c);
        exp_a.push_back(v);
        exp_b.push_back(v < 0 ? 0 : v);
      end
    n_res = 0;
  endtask

  task automatic wr_coef(input int addr, input int val);
    bus_a.coef_wr   = 1'b1;
    bus_a.coef_addr = 4'(addr);
    bus_a.coef_data = 8'(val);
    @(posedge clk); #1;
    bus_a.coef_wr = 1'b0;
  endtask

  task automatic load_kernel(input int k);
    int v;
    for (int i = 0; i < 9; i++) begin
      if (k == K_ONES)    v = 1;
      else if (k == K_ID) v = (i == 4) ? 1 : 0;
      else                v = (i == 0) ? -1 : 0;
      wr_coef(i, v);
    end
  endtask

  always @(posedge clk) cyc_n++;

  // output monitor: handshakes checked in order, stalls must hold data and block input
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_a.pix_valid && bus_a.pix_ready && first_acc < 0) first_acc = cyc_n;
      if (bus_a.out_valid && first_ov < 0) first_ov = cyc_n;
      if (bus_a.out_valid && bus_a.out_ready) begin
        last_hs = cyc_n;
        n_res++;
        if (exp_a.size() == 0) chk("res_a_extra", 1, 0);
        else chk("res_a", $signed(bus_a.out_data), exp_a.pop_front());
      end else if (bus_a.busy && bus_a.out_valid) begin
        chk("stall_rdy", bus_a.pix_ready, 0);
        if (exp_a.size() > 0) chk("stall_data", $signed(bus_a.out_data), exp_a[0]);
      end
      if (bus_b.out_valid && bus_b.out_ready) begin
        if (exp_b.size() == 0) chk("res_b_extra", 1, 0);
        else chk("res_b", $signed(bus_b.out_data), exp_b.pop_front());
      end
    end
  end

  task automatic run_frame(input int pat, input int bp, input int abort_at,
                           input bit inj, input bit chk_time);
    int idx = 0;
    int cnt = 0;
    bit injected = 1'b0;
    bit seen = 1'b0;
    first_acc = -1;
    first_ov  = -1;
    last_hs   = -1;
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    @(negedge clk);
    chk("start_busy", bus_a.busy, 1);
    chk("start_rdy", bus_a.pix_ready, 1);
    @(posedge clk); #1;
    while (idx < IMG_W * IMG_H && cnt < 3000) begin
      if (abort_at > 0 && idx == abort_at) break;
      bus_a.pix_valid = 1'b1;
      bus_a.pix_in    = DATA_W'(pix(pat, idx / IMG_W, idx % IMG_W));
      if (bp == 1 && cnt >= 30 && cnt < 35)  bus_a.out_ready = 1'b0;
      else if (bp == 1 && cnt >= 40)         bus_a.out_ready = 1'($urandom_range(0, 1));
      else                                   bus_a.out_ready = 1'b1;
      if (inj && !injected && idx == 30) begin
        bus_a.coef_wr   = 1'b1;
        bus_a.coef_addr = 4'd4;
        bus_a.coef_data = 8'sd7;
        bus_a.start     = 1'b1;
        injected = 1'b1;
      end else begin
        bus_a.coef_wr = 1'b0;
        bus_a.start   = 1'b0;
      end
      @(negedge clk);
      if (bus_a.pix_ready) idx++;
      @(posedge clk); #1;
      cnt++;
    end
    bus_a.pix_valid = 1'b0;
    bus_a.coef_wr   = 1'b0;
    bus_a.start     = 1'b0;
    if (abort_at > 0) return;
    chk("feed_all", idx, IMG_W * IMG_H);
    bus_a.out_ready = 1'b1;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      if (bus_a.done) begin
        seen = 1'b1;
        chk("done_busy", bus_a.busy, 0);
        chk("done_gap", cyc_n - last_hs, 1);
      end
    end
    chk("done_seen", seen, 1);
    @(negedge clk);
    chk("done_pulse", bus_a.done, 0);
    chk("n_res", n_res, NRES);
    chk("left_a", exp_a.size(), 0);
    chk("left_b", exp_b.size(), 0);
    if (chk_time) chk("latency", first_ov - first_acc, 2 * IMG_W + 3);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.coef_wr   = 1'b0;
    bus_a.coef_addr = '0;
    bus_a.coef_data = '0;
    bus_a.start     = 1'b0;
    bus_a.pix_valid = 1'b0;
    bus_a.pix_in    = '0;
    bus_a.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_pix_ready", bus_a.pix_ready, 0);
    chk("rst_out_valid", bus_a.out_valid, 0);
    chk("rst_out_data", $signed(bus_a.out_data), 0);
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_done", bus_a.done, 0);
    @(posedge clk); #1;

    // identity kernel on a ramp, full throughput, with latency check
    load_kernel(K_ID);
    build_exp(K_ID, P_RAMP);
    run_frame(P_RAMP, 0, 0, 1'b0, 1'b1);

    // all-ones kernel on a saturated image
    load_kernel(K_ONES);
    build_exp(K_ONES, P_FULL);
    run_frame(P_FULL, 0, 0, 1'b0, 1'b0);

    // negated top-left tap: negative results on A, clamped to 0 on B
    load_kernel(K_NEG);
    build_exp(K_NEG, P_RAMP);
    run_frame(P_RAMP, 0, 0, 1'b0, 1'b0);

    // identity with a 5-cycle stall then random downstream backpressure
    load_kernel(K_ID);
    build_exp(K_ID, P_RAMP);
    run_frame(P_RAMP, 1, 0, 1'b0, 1'b0);

    // mid-frame reset with all-ones loaded, then identity via one tap write only
    load_kernel(K_ONES);
    build_exp(K_ONES, P_RAMP);
    run_frame(P_RAMP, 0, 20, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", bus_a.out_valid, 0);
    chk("mid_rst_busy", bus_a.busy, 0);
    chk("mid_rst_pix_ready", bus_a.pix_ready, 0);
    chk("mid_rst_out_data", $signed(bus_a.out_data), 0);
    exp_a.delete();
    exp_b.delete();
    @(posedge clk); #1;
    wr_coef(4, 1);
    build_exp(K_ID, P_RAMP);
    run_frame(P_RAMP, 0, 0, 1'b0, 1'b1);

    // coefficient write and start during RUN are ignored
    build_exp(K_ID, P_RAMP);
    run_frame(P_RAMP, 0, 0, 1'b1, 1'b0);

    // out-of-range coefficient address in IDLE is ignored
    wr_coef(12, 5);
    build_exp(K_ID, P_RAMP);
    run_frame(P_RAMP, 0, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
